// File: rtl/seq_match_logger_pkg.sv
// Shared defaults and event record layout for the sequence-match logger.
package seq_match_logger_pkg;

  localparam int IDX_W   = 8;
  localparam int STATE_W = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [STATE_W-1:0] state;
  } evt_t;

endpackage

// File: rtl/seq_match_logger_event_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers and occupancy output.
module event_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    level   = wr_q - rd_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    // Zero head when empty so readout is clean after reset
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seq_match_logger.sv
// Stamps detector matches with a bit index and buffers them for readout.
module seq_match_logger
  import seq_match_logger_pkg::*;
#(
  parameter int IDX_W   = seq_match_logger_pkg::IDX_W,
  parameter int STATE_W = seq_match_logger_pkg::STATE_W,
  parameter int DEPTH   = seq_match_logger_pkg::DEPTH,
  parameter int CNT_W   = seq_match_logger_pkg::CNT_W,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_en,
  input  logic               y_in,
  input  logic [STATE_W-1:0] state_in,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [IDX_W-1:0]   rd_idx,
  output logic [STATE_W-1:0] rd_state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               overflow,
  output logic [LW-1:0]      level
);

  localparam int WIDTH = IDX_W + STATE_W;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             match, push, pop;
  logic             full, empty;
  logic [WIDTH-1:0] head;

  always_comb begin
    match = bit_en & y_in;
    pop   = ~empty & rd_ready;
    push  = match & (~full | pop);
    idx_d = bit_en ? idx_q + IDX_W'(1) : idx_q;
    cnt_d = (match && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = ovf_q | (match & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  event_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({idx_q, state_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rd_valid  = ~empty;
  assign rd_idx    = head[WIDTH-1:STATE_W];
  assign rd_state  = head[STATE_W-1:0];
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule
